// File: rtl/zap_adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-in adder among NREQ requesters.
// 64-bit requests run as two adder passes (low word, then high word with carry).
module zap_adder_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ-1:0]   i_long,
   input  logic [NREQ*64-1:0] i_a,
   input  logic [NREQ*64-1:0] i_b,
   input  logic [NREQ-1:0]   i_cin,
   output logic [NREQ-1:0]   o_gnt,
   output logic              o_busy,
   output logic              o_valid,
   output logic [IDW-1:0]    o_id,
   output logic [63:0]       o_sum,
   output logic              o_cout
);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

   state_t          r_state;
   state_t          w_next;

   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_idx;
   logic [63:0]     r_a;
   logic [63:0]     r_b;
   logic            r_cin;
   logic            r_long;
   logic            r_carry;
   logic [31:0]     r_lo;
   logic [63:0]     r_sum;
   logic            r_cout;
   logic [IDW-1:0]  r_id;

   logic            w_found;
   logic [IDW-1:0]  w_win;
   logic            w_take;
   logic [63:0]     w_win_a;
   logic [63:0]     w_win_b;
   logic            w_win_cin;
   logic            w_win_long;
   logic [31:0]     w_add_a;
   logic [31:0]     w_add_b;
   logic            w_add_cin;
   logic [32:0]     w_add_sum;

   // Two scans: indices above the pointer first, then wrap to the bottom.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && i_req[k] && (k[IDW-1:0] > r_ptr)) begin
            w_found = 1'b1;
            w_win   = k[IDW-1:0];
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && i_req[k]) begin
            w_found = 1'b1;
            w_win   = k[IDW-1:0];
         end
      end
   end

   always_comb begin
      w_win_a    = '0;
      w_win_b    = '0;
      w_win_cin  = 1'b0;
      w_win_long = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_win == k[IDW-1:0]) begin
            w_win_a    = i_a[64*k +: 64];
            w_win_b    = i_b[64*k +: 64];
            w_win_cin  = i_cin[k];
            w_win_long = i_long[k];
         end
      end
   end

   assign w_take = (r_state == S_IDLE) && w_found;

   // The single shared adder; HI selects the upper words and the chained carry.
   always_comb begin
      if (r_state == S_HI) begin
         w_add_a   = r_a[63:32];
         w_add_b   = r_b[63:32];
         w_add_cin = r_carry;
      end else begin
         w_add_a   = r_a[31:0];
         w_add_b   = r_b[31:0];
         w_add_cin = r_cin;
      end
   end

   assign w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {32'd0, w_add_cin};

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_found ? S_LO : S_IDLE;
         S_LO:    w_next = r_long ? S_HI : S_RESP;
         S_HI:    w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Grant is combinational, so it is gated by reset to stay quiet while held.
   always_comb begin
      o_gnt = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (w_take && i_reset_n && (w_win == k[IDW-1:0])) begin
            o_gnt[k] = 1'b1;
         end
      end
      o_busy  = (r_state != S_IDLE);
      o_valid = (r_state == S_RESP);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ptr   <= IDW'(NREQ - 1);
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
         r_long  <= 1'b0;
         r_carry <= 1'b0;
         r_lo    <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_id    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_a    <= w_win_a;
                  r_b    <= w_win_b;
                  r_cin  <= w_win_cin;
                  r_long <= w_win_long;
                  r_idx  <= w_win;
               end
            end
            S_LO: begin
               r_lo    <= w_add_sum[31:0];
               r_carry <= w_add_sum[32];
               if (!r_long) begin
                  r_sum  <= {32'd0, w_add_sum[31:0]};
                  r_cout <= w_add_sum[32];
                  r_id   <= r_idx;
               end
            end
            S_HI: begin
               r_carry <= w_add_sum[32];
               r_sum   <= {w_add_sum[31:0], r_lo};
               r_cout  <= w_add_sum[32];
               r_id    <= r_idx;
            end
            S_RESP: begin
               r_ptr <= r_idx;
            end
            default: begin
               r_ptr <= r_ptr;
            end
         endcase
      end
   end

   assign o_sum  = r_sum;
   assign o_cout = r_cout;
   assign o_id   = r_id;

endmodule
